rom_sel_sequencer: RTL



---
 rtl/rom_seq_pkg.sv | 39 +++
 rtl/seq_lfsr16.sv | 21 ++
 rtl/rom_sel_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared widths, LFSR mask, FSM states and select helpers for the ROM selector sequencer
package rom_seq_pkg;
    localparam int ROM1_W = 5;
    localparam int ROM_W = 2;
    localparam int ROM6_W = 3;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam int ROM6_MOD = 5;

    typedef enum logic [1:0] {IDLE, DRIVE, PRESENT, DONE} state_t;

    typedef struct packed {
        logic [ROM_W-1:0]  rom2;
        logic [ROM_W-1:0]  rom3;
        logic [ROM_W-1:0]  rom4;
        logic [ROM_W-1:0]  rom5;
        logic [ROM6_W-1:0] rom6;
    } sel_t;

    // Galois right-shift step
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : '0);
    endfunction

    // rom6 only has five entries, so fold 5..7 back onto 0..2
    function automatic logic [ROM6_W-1:0] rom6_map(input logic [ROM6_W-1:0] f);
        return (f >= ROM6_W'(ROM6_MOD)) ? f - ROM6_W'(ROM6_MOD) : f;
    endfunction

    function automatic sel_t to_sel(input logic [LFSR_W-1:0] l);
        sel_t s;
        s.rom2 = l[1:0];
        s.rom3 = l[3:2];
        s.rom4 = l[5:4];
        s.rom5 = l[7:6];
        s.rom6 = rom6_map(l[10:8]);
        return s;
    endfunction
endpackage

// File: rtl/seq_lfsr16.sv
// seq_lfsr16: 16-bit Galois LFSR with seed load and single-step advance
module seq_lfsr16
    import rom_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);
    logic [LFSR_W-1:0] r_value;

    // reset and load both restart the sequence from the seed
    always_ff @(posedge clk) begin
        if (rst || load) r_value <= seed;
        else if (step)   r_value <= lfsr_next(r_value);
    end

    assign value = r_value;
endmodule

// File: rtl/rom_sel_sequencer.sv
// rom_sel_sequencer: walks rom1 over 0..ADDR_MAX with LFSR-driven rom2..rom6, settles each set then handshakes it out (optional SEQ_TAIL_EN adds rom1=0,1 tail steps)
module rom_sel_sequencer
    import rom_seq_pkg::*;
#(
    parameter int                ADDR_MAX  = 27,
    parameter int                SETTLE    = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_ready,
    output logic [ROM1_W-1:0] rom1_sel,
    output logic [ROM_W-1:0]  rom2_sel,
    output logic [ROM_W-1:0]  rom3_sel,
    output logic [ROM_W-1:0]  rom4_sel,
    output logic [ROM_W-1:0]  rom5_sel,
    output logic [ROM6_W-1:0] rom6_sel,
    output logic              sel_valid,
    output logic              busy,
    output logic              done
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROM1_W-1:0] r_rom1;
    sel_t              r_sel;
    logic [3:0]        r_cnt;
    logic [LFSR_W-1:0] w_lfsr;
    logic [LFSR_W-1:0] w_src;
    logic              w_start;
    logic              w_hs;
    logic              w_step;
    logic              w_last;
    logic              w_tail;

    assign w_start = (r_state == IDLE) && start;
    assign w_hs    = (r_state == PRESENT) && sample_ready;
    assign w_src   = w_start ? LFSR_SEED : lfsr_next(w_lfsr);

`ifdef SEQ_TAIL_EN
    logic [1:0] r_tail;

    assign w_last = (r_tail == 2'd2);
    assign w_step = w_hs && (r_tail == 2'd0) && (r_rom1 != ROM1_W'(ADDR_MAX));
    assign w_tail = w_hs && !w_last && !w_step;

    // tail phase: 0 = main walk, 1 = rom1=0 tail step, 2 = rom1=1 tail step
    always_ff @(posedge clk) begin
        if (rst || w_start) r_tail <= 2'd0;
        else if (w_tail)    r_tail <= r_tail + 2'd1;
    end
`else
    assign w_last = (r_rom1 == ROM1_W'(ADDR_MAX));
    assign w_step = w_hs && !w_last;
    assign w_tail = 1'b0;
`endif

    seq_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start),
        .seed (LFSR_SEED),
        .step (w_step),
        .value(w_lfsr)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state: settle in DRIVE, wait for the handshake in PRESENT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? DRIVE : IDLE;
            DRIVE:   w_state_nxt = (r_cnt == 4'd0) ? PRESENT : DRIVE;
            PRESENT: w_state_nxt = sample_ready ? (w_last ? DONE : DRIVE) : PRESENT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // selector registers and settle counter; tail steps keep rom2..rom6 frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom1 <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
        end else if (w_start || w_step) begin
            r_rom1 <= w_start ? '0 : r_rom1 + 1'b1;
            r_sel  <= to_sel(w_src);
            r_cnt  <= 4'(SETTLE - 1);
        end else if (w_tail) begin
`ifdef SEQ_TAIL_EN
            r_rom1 <= ROM1_W'(r_tail);
`endif
            r_cnt  <= 4'(SETTLE - 1);
        end else if (r_state == DRIVE && r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign rom1_sel  = r_rom1;
    assign rom2_sel  = r_sel.rom2;
    assign rom3_sel  = r_sel.rom3;
    assign rom4_sel  = r_sel.rom4;
    assign rom5_sel  = r_sel.rom5;
    assign rom6_sel  = r_sel.rom6;
    assign sel_valid = (r_state == PRESENT);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
endmodule
